sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for same-domain buffering between producer and consumer blocks. It is the successor to the dual-clock FIFO for paths that need no clock crossing. Over that block it adds:
- a correct-width occupancy count;
- programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags;
- a synchronous flush;
- a first-word-fall-through (FWFT) read mode.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_mem.sv | 25 ++
 rtl/sync_fifo.sv | 134 +++++++++++++
 tb/tb_sync_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
// ADDR_W/CNT_W give the pointer and count widths for the default depth.
package fifo_pkg;

    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned ADDR_W        = $clog2(DEPTH_DEFAULT);
    localparam int unsigned CNT_W         = ADDR_W + 1;

    typedef enum logic {
        STANDARD = 1'b0,
        FWFT     = 1'b1
    } fifo_mode_e;

    // Occupancy after one edge; a simultaneous accepted read and write cancel.
    function automatic int unsigned next_count(input int unsigned cnt,
                                               input logic        wr_acc,
                                               input logic        rd_acc);
        int unsigned res;
        res = cnt;
        if (wr_acc && !rd_acc) begin
            res = cnt + 1;
        end else if (rd_acc && !wr_acc) begin
            res = cnt - 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// The array has no reset; emptiness is tracked by the surrounding control.
module fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] write_addr,
    input  logic [WIDTH-1:0]         write_data,
    input  logic [$clog2(DEPTH)-1:0] read_addr,
    output logic [WIDTH-1:0]         read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/flags, sticky error flags,
// synchronous flush and an optional first-word-fall-through read port.
module sync_fifo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   write_en,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   read_en,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    import fifo_pkg::next_count;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             full_nxt;
    logic             empty_nxt;
    logic             af_nxt;
    logic             ae_nxt;
    logic             ovf_nxt;
    logic             udf_nxt;
    logic [WIDTH-1:0] rd_data;

    // Acceptance looks only at the registered flags, so a read never frees a
    // slot for a same-cycle write into a full FIFO (and vice versa when empty).
    always_comb begin
        wr_acc     = write_en && !full && !clear;
        rd_acc     = read_en && !empty && !clear;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        ovf_nxt    = overflow;
        udf_nxt    = underflow;
        if (clear) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
            ovf_nxt    = 1'b0;
            udf_nxt    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_nxt = wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_nxt = rd_ptr + AW'(1);
            end
            count_nxt = CW'(next_count(32'(count), wr_acc, rd_acc));
            ovf_nxt   = overflow || (write_en && full);
            udf_nxt   = underflow || (read_en && empty);
        end
        full_nxt  = (count_nxt == CW'(DEPTH));
        empty_nxt = (count_nxt == '0);
        af_nxt    = (32'(count_nxt) >= AF_LEVEL);
        ae_nxt    = (32'(count_nxt) <= AE_LEVEL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= full_nxt;
            empty        <= empty_nxt;
            almost_full  <= af_nxt;
            almost_empty <= ae_nxt;
            overflow     <= ovf_nxt;
            underflow    <= udf_nxt;
        end
    end

    fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk       (clk),
        .write_en  (wr_acc),
        .write_addr(wr_ptr),
        .write_data(data_in),
        .read_addr (rd_ptr),
        .read_data (rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word falls through; its value is meaningless while empty.
        assign data_out = rd_data;
    end else begin : g_std
        logic [WIDTH-1:0] data_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
            end else if (clear) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= rd_data;
            end
        end

        assign data_out = data_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one standard-mode and one FWFT instance
// share stimulus; a vector table covers the main flows, hand sequences the rest.
module tb_sync_fifo;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = fifo_pkg::CNT_W;

    typedef struct {
        logic        clr;
        logic        we;
        logic        re;
        logic [31:0] din;
        logic [3:0]  cnt;
        logic        ovf;
        logic        udf;
        logic [31:0] dout;
    } vec_t;

    logic          clk;
    logic          reset_n;
    logic          clear;
    logic          write_en;
    logic          read_en;
    logic [W-1:0]  data_in;

    logic [W-1:0]  s_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [CW-1:0] s_count;
    logic [W-1:0]  f_dout;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [CW-1:0] f_count;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(32'(fifo_pkg::STANDARD)),
                .AF_LEVEL(D - 2), .AE_LEVEL(2)) u_std (
        .clk(clk), .reset_n(reset_n), .clear(clear), .write_en(write_en),
        .data_in(data_in), .read_en(read_en), .data_out(s_dout),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(32'(fifo_pkg::FWFT)),
                .AF_LEVEL(D - 2), .AE_LEVEL(2)) u_ft (
        .clk(clk), .reset_n(reset_n), .clear(clear), .write_en(write_en),
        .data_in(data_in), .read_en(read_en), .data_out(f_dout),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic we, input logic re,
                                input logic [31:0] din, input logic [3:0] cnt,
                                input logic ovf, input logic udf, input logic [31:0] dout);
        vec_t v;
        v.clr = clr; v.we = we; v.re = re; v.din = din;
        v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.dout = dout;
        return v;
    endfunction

    // Drive between edges, sample 1 time unit after the rising edge.
    task automatic step(input logic clr, input logic we, input logic re, input logic [31:0] din);
        @(negedge clk);
        clear = clr; write_en = we; read_en = re; data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; clear = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(s_count), 0);
        check("rst_flags", {26'd0, s_full, s_empty, s_af, s_ae, s_ovf, s_udf}, 32'b010100);
        check("rst_dout", s_dout, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [5:0] exp_flags;
        reset_n = 1'b0; clear = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;

        // Fill, overflow, drain, underflow, clear with write.
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 32'(i), 4'(i), 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'hDEAD, 8, 1, 0, 0));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 0, 1, 0, 4'(8 - i), 1, 0, 32'(i)));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 8));
        vecs.push_back(mk(1, 1, 0, 32'h55, 0, 0, 0, 0));
        // Read+write on empty: write lands, read rejected.
        vecs.push_back(mk(0, 1, 1, 32'h11, 1, 0, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 32'h12 + 32'(i), 4'(2 + i), 0, 1, 0));
        // Ten cycles of read+write at count 4.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 1, 1, 32'h20 + 32'(i), 4, 0, 1,
                              (i < 4) ? 32'h11 + 32'(i) : 32'h20 + 32'(i - 4)));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 0, 32'h30 + 32'(i), 4'(5 + i), 0, 1, 32'h25));
        // Read+write on full: read lands, write rejected.
        vecs.push_back(mk(0, 1, 1, 32'h40, 7, 1, 1, 32'h26));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        // 20 writes with trailing reads: both pointers wrap twice.
        vecs.push_back(mk(0, 1, 0, 32'h100, 1, 0, 0, 0));
        for (int i = 1; i <= 19; i++)
            vecs.push_back(mk(0, 1, 1, 32'h100 + 32'(i), 1, 0, 0, 32'h100 + 32'(i - 1)));
        vecs.push_back(mk(1, 1, 0, 32'h77, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));

        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].we, vecs[i].re, vecs[i].din);
            exp_flags = {vecs[i].cnt == 4'd8, vecs[i].cnt == 4'd0, vecs[i].cnt >= 4'd6,
                         vecs[i].cnt <= 4'd2, vecs[i].ovf, vecs[i].udf};
            check($sformatf("v%0d_count", i), 32'(s_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_flags", i),
                  {26'd0, s_full, s_empty, s_af, s_ae, s_ovf, s_udf}, {26'd0, exp_flags});
            check($sformatf("v%0d_dout", i), s_dout, vecs[i].dout);
            check($sformatf("v%0d_ft_count", i), 32'(f_count), 32'(vecs[i].cnt));
        end

        // FWFT fall-through and standard one-cycle read latency side by side.
        do_reset();
        step(0, 1, 0, 32'hA5);
        check("ft_a5_visible", f_dout, 32'hA5);
        check("ft_a5_nonempty", 32'(f_empty), 0);
        check("std_a5_not_yet", s_dout, 0);
        step(0, 1, 0, 32'hB6);
        check("ft_head_held", f_dout, 32'hA5);
        check("ft_count2", 32'(f_count), 2);
        step(0, 0, 1, 0);
        check("ft_next_word", f_dout, 32'hB6);
        check("std_read_a5", s_dout, 32'hA5);
        step(0, 0, 1, 0);
        check("std_read_b6", s_dout, 32'hB6);
        check("ft_empty", 32'(f_empty), 1);
        step(0, 0, 1, 0);
        check("udf_both", {30'd0, s_udf, f_udf}, 32'b11);
        check("std_dout_held", s_dout, 32'hB6);
        step(0, 1, 0, 32'hC1);
        step(0, 1, 0, 32'hC2);
        step(0, 1, 0, 32'hC3);
        check("burst_count", 32'(s_count), 3);

        // Asynchronous reset in the middle of a write burst.
        #2 reset_n = 1'b0;
        #1;
        check("arst_count", 32'(s_count), 0);
        check("arst_flags", {26'd0, s_full, s_empty, s_af, s_ae, s_ovf, s_udf}, 32'b010100);
        check("arst_dout", s_dout, 0);
        check("arst_ft_count", 32'(f_count), 0);
        check("arst_ft_udf", 32'(f_udf), 0);
        @(posedge clk);
        #1;
        check("arst_hold_count", 32'(s_count), 0);
        @(negedge clk);
        reset_n = 1'b1; write_en = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_empty", 32'(s_empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
